// File: rtl/decode_queue.sv
// decode_queue
//   DEPTH-entry FIFO of RV32I instructions that are decoded as they are
//   enqueued. The oldest decoded entry is presented to ROB/RS issue logic
//   under a valid/ready handshake. A synchronous flush (branch mispredict)
//   empties the queue.
//
// Ports
//   clock, reset         rising-edge clock; asynchronous active-high reset
//   fetchValid/Ready     fetch-side handshake; fetchReady = (count < DEPTH)
//   fetchInstr, fetchPC  instruction word and its PC
//   flush                discard all queued entries at the next edge
//   issueValid/Ready     issue-side handshake; issueValid = (count != 0)
//   opType .. illegal    decoded fields of the head entry (reset values when empty)
//   pcOut, instrOut      head PC and raw instruction word
//   count                current occupancy
module decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               fetchValid,
    input  logic [31:0]        fetchInstr,
    input  logic [XLEN-1:0]    fetchPC,
    output logic               fetchReady,
    input  logic               flush,
    input  logic               issueReady,
    output logic               issueValid,
    output logic [6:0]         opType,
    output logic [2:0]         opSubType,
    output logic               opFlag,
    output logic [4:0]         destReg,
    output logic [4:0]         reg1,
    output logic [4:0]         reg2,
    output logic               useReg1,
    output logic               useReg2,
    output logic               writesDest,
    output logic [XLEN-1:0]    imm,
    output logic [XLEN-1:0]    pcOut,
    output logic [31:0]        instrOut,
    output logic               illegal,
    output logic [PTR_W:0]     count
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);

    typedef struct packed {
        logic [6:0]      op_type;
        logic [2:0]      sub_type;
        logic            flag;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            use1;
        logic            use2;
        logic            wr;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            illegal;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           dec;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_enq;
    logic             do_deq;

    assign fetchReady = (count < FULL_COUNT);
    assign issueValid = (count != '0);
    assign do_enq     = fetchValid && fetchReady;
    assign do_deq     = issueValid && issueReady;

    // Decode of the incoming word; the result is what gets stored.
    always_comb begin
        logic [31:0] i;
        logic        is_shift;
        i = fetchInstr;
        // NOTE: every field gets a default before the case so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        dec          = '0;
        dec.op_type  = i[6:0];
        dec.sub_type = i[14:12];
        dec.rd       = i[11:7];
        dec.rs1      = i[19:15];
        dec.rs2      = i[24:20];
        dec.pc       = fetchPC;
        dec.instr    = i;
        is_shift     = (i[13:12] == 2'b01);  // funct3 001 (SLLI) or 101 (SRLI/SRAI)
        unique case (i[6:0])
            OPC_LUI, OPC_AUIPC: begin
                dec.sub_type = 3'b111;
                dec.wr       = 1'b1;
                dec.imm      = {{(XLEN-32){i[31]}}, i[31:12], 12'b0};
            end
            OPC_JAL: begin
                dec.sub_type = 3'b111;
                dec.wr       = 1'b1;
                dec.imm      = {{(XLEN-20){i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD: begin
                dec.use1 = 1'b1;
                dec.wr   = 1'b1;
                dec.imm  = {{(XLEN-12){i[31]}}, i[31:20]};
            end
            OPC_BRANCH: begin
                dec.use1 = 1'b1;
                dec.use2 = 1'b1;
                dec.imm  = {{(XLEN-12){i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            end
            OPC_STORE: begin
                dec.use1 = 1'b1;
                dec.use2 = 1'b1;
                dec.imm  = {{(XLEN-12){i[31]}}, i[31:25], i[11:7]};
            end
            OPC_OP_IMM: begin
                dec.use1 = 1'b1;
                dec.wr   = 1'b1;
                if (is_shift) begin
                    dec.flag = i[30];
                    dec.imm  = {{(XLEN-5){1'b0}}, i[24:20]};
                end else begin
                    dec.imm  = {{(XLEN-12){i[31]}}, i[31:20]};
                end
            end
            OPC_OP: begin
                dec.flag = i[30];
                dec.use1 = 1'b1;
                dec.use2 = 1'b1;
                dec.wr   = 1'b1;
            end
            OPC_FENCE: begin
                dec.imm = {{(XLEN-8){1'b0}}, i[27:20]};
            end
            default: begin
                dec.sub_type = 3'b111;
                dec.illegal  = 1'b1;
            end
        endcase
        // x0 is never a real destination.
        if (i[11:7] == 5'd0)
            dec.wr = 1'b0;
    end

    // Pointer and occupancy state. Flush wins over any same-edge handshake.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_deq)
                rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({do_enq, do_deq})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the entry storage has no reset; an entry is only ever read after
    // it has been written, and the empty-queue output mask hides stale data.
    always_ff @(posedge clock) begin
        if (do_enq && !flush)
            mem[wr_ptr] <= dec;
    end

    assign head = mem[rd_ptr];

    // Head presentation, masked to reset values while the queue is empty.
    always_comb begin
        opType     = 7'h7F;
        opSubType  = 3'b111;
        opFlag     = 1'b0;
        destReg    = '0;
        reg1       = '0;
        reg2       = '0;
        useReg1    = 1'b0;
        useReg2    = 1'b0;
        writesDest = 1'b0;
        imm        = '0;
        pcOut      = '0;
        instrOut   = '0;
        illegal    = 1'b0;
        if (issueValid) begin
            opType     = head.op_type;
            opSubType  = head.sub_type;
            opFlag     = head.flag;
            destReg    = head.rd;
            reg1       = head.rs1;
            reg2       = head.rs2;
            useReg1    = head.use1;
            useReg2    = head.use2;
            writesDest = head.wr;
            imm        = head.imm;
            pcOut      = head.pc;
            instrOut   = head.instr;
            illegal    = head.illegal;
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue
//   Directed scenarios followed by a randomized run for decode_queue
//   (XLEN=32, DEPTH=4). Expected values come from a queue-based model that
//   holds raw {instr, pc} pairs and decodes the head with integer arithmetic.
module tb_decode_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic              fetchValid;
    logic [31:0]       fetchInstr;
    logic [XLEN-1:0]   fetchPC;
    logic              fetchReady;
    logic              flush;
    logic              issueReady;
    logic              issueValid;
    logic [6:0]        opType;
    logic [2:0]        opSubType;
    logic              opFlag;
    logic [4:0]        destReg;
    logic [4:0]        reg1;
    logic [4:0]        reg2;
    logic              useReg1;
    logic              useReg2;
    logic              writesDest;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pcOut;
    logic [31:0]       instrOut;
    logic              illegal;
    logic [PTR_W:0]    count;

    decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clock(clock), .reset(reset),
        .fetchValid(fetchValid), .fetchInstr(fetchInstr), .fetchPC(fetchPC),
        .fetchReady(fetchReady), .flush(flush),
        .issueReady(issueReady), .issueValid(issueValid),
        .opType(opType), .opSubType(opSubType), .opFlag(opFlag),
        .destReg(destReg), .reg1(reg1), .reg2(reg2),
        .useReg1(useReg1), .useReg2(useReg2), .writesDest(writesDest),
        .imm(imm), .pcOut(pcOut), .instrOut(instrOut),
        .illegal(illegal), .count(count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  sub;
        logic        flag;
        logic        use1;
        logic        use2;
        logic        wr;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    ent_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   issued = 0;
    bit   last_enq;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sign-extend the low 'bits' bits of v by arithmetic.
    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        logic [31:0] m;
        logic [31:0] s;
        m = (bits == 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
        s = 32'd1 << (bits - 1);
        return ((v & m) ^ s) - s;
    endfunction

    function automatic exp_t model_decode(input logic [31:0] w);
        exp_t e;
        int   f3;
        bit   rd_nz;
        f3     = int'((w >> 12) & 7);
        rd_nz  = ((w >> 7) & 31) != 0;
        e.op   = w[6:0];
        e.sub  = 3'(f3);
        e.flag = 0; e.use1 = 0; e.use2 = 0; e.wr = 0; e.imm = 0; e.ill = 0;
        case (w[6:0])
            7'b0110111, 7'b0010111: begin
                e.sub = 3'd7; e.wr = rd_nz; e.imm = w & 32'hFFFF_F000;
            end
            7'b1101111: begin
                e.sub = 3'd7; e.wr = rd_nz;
                e.imm = sext((((w >> 31) & 1) << 20) | (((w >> 12) & 255) << 12) |
                             (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1), 21);
            end
            7'b1100111, 7'b0000011: begin
                e.use1 = 1; e.wr = rd_nz; e.imm = sext(w >> 20, 12);
            end
            7'b1100011: begin
                e.use1 = 1; e.use2 = 1;
                e.imm = sext((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
                             (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1), 13);
            end
            7'b0100011: begin
                e.use1 = 1; e.use2 = 1;
                e.imm = sext(((w >> 25) << 5) | ((w >> 7) & 31), 12);
            end
            7'b0010011: begin
                e.use1 = 1; e.wr = rd_nz;
                if (f3 == 1 || f3 == 5) begin
                    e.flag = w[30]; e.imm = (w >> 20) & 31;
                end else begin
                    e.imm = sext(w >> 20, 12);
                end
            end
            7'b0110011: begin
                e.use1 = 1; e.use2 = 1; e.wr = rd_nz; e.flag = w[30];
            end
            7'b0001111: e.imm = (w >> 20) & 255;
            default: begin
                e.sub = 3'd7; e.ill = 1;
            end
        endcase
        return e;
    endfunction

    // Compare every DUT output with the model's view of the queue.
    task automatic check_head(input string tag);
        exp_t e;
        check({tag, "_count"}, 64'(count), 64'(q.size()));
        check({tag, "_issueValid"}, 64'(issueValid), 64'(q.size() != 0));
        check({tag, "_fetchReady"}, 64'(fetchReady), 64'(q.size() < DEPTH));
        if (q.size() == 0) begin
            check({tag, "_opType"}, 64'(opType), 64'h7F);
            check({tag, "_opSubType"}, 64'(opSubType), 64'h7);
            check({tag, "_others"},
                  64'({opFlag, destReg, reg1, reg2, useReg1, useReg2, writesDest, illegal}), 64'd0);
            check({tag, "_immpc"}, {imm, pcOut}, 64'd0);
            check({tag, "_instrOut"}, 64'(instrOut), 64'd0);
        end else begin
            e = model_decode(q[0].instr);
            check({tag, "_opType"}, 64'(opType), 64'(e.op));
            check({tag, "_opSubType"}, 64'(opSubType), 64'(e.sub));
            check({tag, "_opFlag"}, 64'(opFlag), 64'(e.flag));
            check({tag, "_regs"}, 64'({destReg, reg1, reg2}),
                  64'({q[0].instr[11:7], q[0].instr[19:15], q[0].instr[24:20]}));
            check({tag, "_use"}, 64'({useReg1, useReg2, writesDest}), 64'({e.use1, e.use2, e.wr}));
            check({tag, "_imm"}, 64'(imm), 64'(e.imm));
            check({tag, "_pcOut"}, 64'(pcOut), 64'(q[0].pc));
            check({tag, "_instrOut"}, 64'(instrOut), 64'(q[0].instr));
            check({tag, "_illegal"}, 64'(illegal), 64'(e.ill));
        end
    endtask

    // One clock edge with the current inputs; the model follows the handshake rules.
    task automatic cycle();
        bit enq;
        bit deq;
        enq = fetchValid && (q.size() < DEPTH);
        deq = issueReady && (q.size() != 0);
        @(posedge clock);
        last_enq = 0;
        if (flush) begin
            q.delete();
        end else begin
            if (deq) begin
                void'(q.pop_front());
                issued++;
            end
            if (enq) begin
                q.push_back('{fetchInstr, fetchPC});
                last_enq = 1;
            end
        end
        @(negedge clock);
    endtask

    task automatic push_one(input logic [31:0] w, input logic [31:0] pc, input string tag);
        fetchValid = 1; fetchInstr = w; fetchPC = pc;
        check_head({tag, "_pre"});
        cycle();
        fetchValid = 0;
        check_head(tag);
    endtask

    task automatic pop_one(input string tag);
        issueReady = 1;
        cycle();
        issueReady = 0;
        check_head(tag);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111};
        logic [6:0] op;
        if ($urandom_range(0, 9) == 0) op = 7'($urandom);
        else                           op = ops[$urandom_range(0, 9)];
        return ($urandom & 32'hFFFF_FF80) | 32'(op);
    endfunction

    initial begin
        logic [31:0] five [5];
        int          idx;
        int          issued_before;

        reset = 1; fetchValid = 0; fetchInstr = 0; fetchPC = 0; flush = 0; issueReady = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 0;
        check_head("reset");

        // Asynchronous reset between edges clears a partly filled queue.
        for (int i = 0; i < 3; i++) push_one(rand_instr(), 32'h1000 + 32'(4 * i), "fill3");
        #2 reset = 1;
        #1;
        q.delete();
        check("async_count", 64'(count), 64'd0);
        check("async_issueValid", 64'(issueValid), 64'd0);
        check("async_fetchReady", 64'(fetchReady), 64'd1);
        check("async_opType", 64'(opType), 64'h7F);
        #1 reset = 0;
        @(negedge clock);
        check_head("after_async");

        // ADDI x5,x1,-1
        push_one(32'hFFF0_8293, 32'h200, "addi");
        check("addi_op", 64'(opType), 64'b0010011);
        check("addi_rd_rs1", 64'({destReg, reg1}), 64'({5'd5, 5'd1}));
        check("addi_imm", 64'(imm), 64'hFFFF_FFFF);
        check("addi_use", 64'({useReg1, useReg2, writesDest}), 64'b101);
        pop_one("addi_pop");

        // BEQ x1,x2,-4
        push_one(32'hFE20_8EE3, 32'h100, "beq");
        check("beq_op", 64'(opType), 64'b1100011);
        check("beq_imm", 64'(imm), 64'hFFFF_FFFC);
        check("beq_use", 64'({useReg2, writesDest}), 64'b10);
        check("beq_pc", 64'(pcOut), 64'h100);
        pop_one("beq_pop");

        // SRAI x3,x4,7 followed by an unsupported opcode
        push_one(32'h4072_5193, 32'h300, "srai");
        push_one(32'h0000_0073, 32'h304, "ecall");
        check("srai_fields", 64'({opSubType, opFlag}), 64'b1011);
        check("srai_imm", 64'(imm), 64'd7);
        pop_one("srai_pop");
        check("ecall_illegal", 64'({illegal, writesDest}), 64'b10);
        pop_one("ecall_pop");

        // Fill to capacity, hold a fifth offer, then drain in order.
        for (int i = 0; i < 5; i++) five[i] = rand_instr();
        idx = 0;
        fetchValid = 1; fetchInstr = five[0]; fetchPC = 32'h400;
        for (int c = 0; c < 5; c++) begin
            cycle();
            if (last_enq) idx++;
            if (idx < 5) begin
                fetchInstr = five[idx]; fetchPC = 32'h400 + 32'(4 * idx);
            end
            check_head("fill");
        end
        check("full_ready", 64'(fetchReady), 64'd0);
        check("full_count", 64'(count), 64'd4);
        check("held_idx", 64'(idx), 64'd4);
        issued_before = issued;
        issueReady = 1;
        for (int c = 0; c < 20 && (q.size() != 0 || idx < 5); c++) begin
            cycle();
            if (last_enq) idx++;
            if (idx == 5) fetchValid = 0;
            check_head("drain");
            check("drain_max", 64'(count <= 4), 64'd1);
        end
        issueReady = 0;
        check("drain_issued", 64'(issued - issued_before), 64'd5);
        check("drain_empty", 64'(issueValid), 64'd0);

        // Flush with a same-edge enqueue and dequeue offered.
        push_one(rand_instr(), 32'h500, "pre_flush0");
        push_one(rand_instr(), 32'h504, "pre_flush1");
        issued_before = issued;
        flush = 1; fetchValid = 1; issueReady = 1; fetchInstr = rand_instr(); fetchPC = 32'h508;
        cycle();
        flush = 0; fetchValid = 0; issueReady = 0;
        check("flush_count", 64'(count), 64'd0);
        check("flush_issueValid", 64'(issueValid), 64'd0);
        check("flush_no_issue", 64'(issued - issued_before), 64'd0);
        check_head("flush");

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            fetchValid = ($urandom_range(0, 3) != 0);
            issueReady = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 24) == 0);
            fetchInstr = rand_instr();
            fetchPC    = $urandom & 32'hFFFF_FFFC;
            cycle();
            check_head("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the single-instruction decoder.
- Buffers fetched RV32I instructions in a DEPTH-entry FIFO and decodes each one at enqueue: opcode class, funct3, funct7 flag, register fields and a sign-extended XLEN immediate.
- Presents the oldest decoded entry to the ROB/reservation-station issue logic with a valid/ready handshake.
- Supports flush on branch mispredict. Sits between instruction fetch and ROB issue.

Parameters:
- XLEN, 32, datapath/immediate/PC width; must be >= 32.
- DEPTH, 4, queue entries; power of two, >= 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- fetchValid  in  1  fetch offers an instruction.
- fetchInstr  in  32  raw instruction word.
- fetchPC  in  XLEN  PC of fetchInstr.
- fetchReady  out  1  queue can accept; = (count < DEPTH).
- flush  in  1  synchronous discard of all queued entries.
- issueReady  in  1  ROB and RS slot available this cycle.
- issueValid  out  1  head entry valid; = (count != 0).
- opType  out  7  head opcode; 7'h7F when issueValid=0.
- opSubType  out  3  funct3; 3'b111 for LUI/AUIPC/JAL/illegal.
- opFlag  out  1  instr[30] for OP and for OP-IMM shifts (funct3 001/101); else 0.
- destReg  out  5  rd.
- reg1  out  5  rs1.
- reg2  out  5  rs2.
- useReg1  out  1  rs1 is a true source.
- useReg2  out  1  rs2 is a true source.
- writesDest  out  1  instruction writes rd and rd != 0.
- imm  out  XLEN  decoded immediate.
- pcOut  out  XLEN  head PC.
- instrOut  out  32  head raw word.
- illegal  out  1  opcode outside the supported set.
- count  out  PTR_W+1  occupancy.

Behaviour:
- Reset: pointers and count = 0; issueValid=0; fetchReady=1; opType=7'h7F; opSubType=3'b111; every other output 0.
- Enqueue: on a rising edge where fetchValid && fetchReady, the decoded entry is written at wrPtr and wrPtr increments mod DEPTH.
- Dequeue: on a rising edge where issueValid && issueReady, rdPtr increments mod DEPTH.
- Latency: an instruction enqueued into an empty queue at edge N is presented with issueValid=1 in the cycle after edge N. There is no combinational fetch-to-issue bypass.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance. When full, fetchReady=0 even if a dequeue occurs in the same cycle.
- Outputs show the head entry. All decoded outputs are forced to their reset values whenever issueValid=0.
- Flush: highest priority below reset. At that edge, pointers and count go to 0, and any enqueue or dequeue in the same cycle is dropped. issueValid=0 in the following cycle.
- Supported opcodes:
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111
  - BRANCH 1100011, LOAD 0000011, STORE 0100011
  - OP-IMM 0010011, OP 0110011, FENCE 0001111
- Any other opcode sets illegal=1, with useReg1=useReg2=writesDest=0 and imm=0.
- Immediates, sign-extended from bit 31 to XLEN unless stated:
  - I-type (JALR, LOAD, non-shift OP-IMM): instr[31:20].
  - S-type: {instr[31:25], instr[11:7]}.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U-type: {instr[31:12], 12'b0}.
  - J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - Shift OP-IMM: instr[24:20], zero-extended.
  - FENCE: instr[27:20], zero-extended.
  - OP: imm = 0.
- Register-use rules:
  - useReg1 = 1 for JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - useReg2 = 1 for BRANCH, STORE, OP.
  - writesDest = 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP when rd != 0.

Test Plan:
- Push 3 entries with issueReady=0, then assert reset mid-cycle -> outputs clear immediately without a clock edge: count=0, issueValid=0, fetchReady=1, opType=7'h7F.
- Push 0xFFF08293 (ADDI x5,x1,-1) -> opType=0010011, opSubType=000, destReg=5, reg1=1, imm=0xFFFFFFFF, useReg1=1, useReg2=0, writesDest=1.
- Push 0xFE208EE3 (BEQ x1,x2,-4), PC=0x100 -> opType=1100011, reg1=1, reg2=2, imm=0xFFFFFFFC, useReg2=1, writesDest=0, pcOut=0x100.
- Push 0x40725193 (SRAI x3,x4,7), then 0x00000073 -> first: opSubType=101, opFlag=1, imm=7; second: illegal=1, writesDest=0.
- DEPTH=4, issueReady=0, offer 5 instructions -> fetchReady=0 after the 4th, count=4, 5th held at input; then raise issueReady -> all 5 issue in order, one per cycle, count never exceeds 4.
- Two entries queued; assert flush with fetchValid=1 and issueReady=1 on the same edge -> count=0 and issueValid=0 next cycle, with no issue and no enqueue recorded.
